aes_block_loader: RTL and testbench

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

---
 rtl/aes_block_loader.sv | 150 +++++++++++++++
 tb/tb_aes_block_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Serial byte loader for an AES core: assembles plaintext and key, restarts the
// core, then waits for a qualified done level or a timeout.
module aes_block_loader #(
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned IGNORE    = 2,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     s_ready,
    input  logic                     s_abort,
    output logic [127:0]             blk_data,
    output logic [32*KEY_WORDS-1:0]  blk_key,
    output logic                     core_rst,
    input  logic                     core_done,
    output logic                     busy,
    output logic                     done_pulse,
    output logic                     err
);

    localparam int unsigned KEY_BITS  = 32 * KEY_WORDS;
    localparam int unsigned KEY_BYTES = 4 * KEY_WORDS;
    localparam int unsigned WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] IGNORE_W   = WCNT_W'(IGNORE);
    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(TIMEOUT - 1);
    localparam logic [4:0]        DATA_LAST  = 5'(15);
    localparam logic [4:0]        KEY_LAST   = 5'(KEY_BYTES - 1);

    typedef enum logic [1:0] {DATA, KEY, START, WAIT} state_e;

    state_e                 state_q, state_d;
    logic [4:0]             bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [127:0]           blk_data_q, blk_data_d;
    logic [KEY_BITS-1:0]    blk_key_q, blk_key_d;
    logic                   core_rst_q, core_rst_d;
    logic                   done_pulse_q, done_pulse_d;
    logic                   err_q, err_d;
    logic                   xfer;

    // s_abort gates ready, so an aborting cycle can never also be a transfer
    assign s_ready    = ((state_q == DATA) || (state_q == KEY)) && !s_abort;
    assign xfer       = s_valid && s_ready;
    assign busy       = (state_q != DATA);
    assign blk_data   = blk_data_q;
    assign blk_key    = blk_key_q;
    assign core_rst   = core_rst_q;
    assign done_pulse = done_pulse_q;
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DATA;
            bcnt_q       <= '0;
            wcnt_q       <= '0;
            blk_data_q   <= '0;
            blk_key_q    <= '0;
            core_rst_q   <= 1'b0;
            done_pulse_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            wcnt_q       <= wcnt_d;
            blk_data_q   <= blk_data_d;
            blk_key_q    <= blk_key_d;
            core_rst_q   <= core_rst_d;
            done_pulse_q <= done_pulse_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        wcnt_d       = wcnt_q;
        blk_data_d   = blk_data_q;
        blk_key_d    = blk_key_q;
        core_rst_d   = 1'b0;
        done_pulse_d = 1'b0;
        err_d        = err_q;

        if (xfer) begin
            err_d = 1'b0;
        end

        case (state_q)
            DATA: begin
                if (s_abort) begin
                    bcnt_d = '0;
                end else if (xfer) begin
                    for (int i = 0; i < 16; i++) begin
                        if (bcnt_q == 5'(i)) begin
                            blk_data_d[127-8*i -: 8] = s_data;
                        end
                    end
                    if (bcnt_q == DATA_LAST) begin
                        state_d = KEY;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            KEY: begin
                if (s_abort) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end else if (xfer) begin
                    for (int i = 0; i < KEY_BYTES; i++) begin
                        if (bcnt_q == 5'(i)) begin
                            blk_key_d[KEY_BITS-1-8*i -: 8] = s_data;
                        end
                    end
                    if (bcnt_q == KEY_LAST) begin
                        state_d    = START;
                        bcnt_d     = '0;
                        core_rst_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                // Early cycles ignore a done level possibly left over from the previous run
                if ((wcnt_q >= IGNORE_W) && core_done) begin
                    state_d      = DATA;
                    wcnt_d       = '0;
                    done_pulse_d = 1'b1;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = DATA;
                    wcnt_d  = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = DATA;
                bcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: nominal load, stale done, timeout,
// abort, back-pressure and mid-operation reset.
module tb_aes_block_loader;

    localparam int unsigned KW = 4;
    localparam logic [127:0] EXP_DATA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic [7:0]      s_data;
    logic            s_ready;
    logic            s_abort;
    logic [127:0]    blk_data;
    logic [32*KW-1:0] blk_key;
    logic            core_rst;
    logic            core_done;
    logic            busy;
    logic            done_pulse;
    logic            err;

    int checks     = 0;
    int failures   = 0;
    int rst_pulses = 0;
    int base;

    aes_block_loader #(.KEY_WORDS(KW), .IGNORE(2), .TIMEOUT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .s_abort   (s_abort),
        .blk_data  (blk_data),
        .blk_key   (blk_key),
        .core_rst  (core_rst),
        .core_done (core_done),
        .busy      (busy),
        .done_pulse(done_pulse),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_rst === 1'b1) rst_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
    endtask

    // Full reference vector with s_valid held high; checks the restart pulse timing
    task automatic load_vector(input string tag);
        for (int i = 0; i < 31; i++) begin
            if (i < 16) send(8'(i * 17));
            else        send(8'(i - 16));
        end
        check({tag, "_no_early_core_rst"}, core_rst, 1'b0);
        send(8'h0f);
        check({tag, "_core_rst"}, core_rst, 1'b1);
        check({tag, "_blk_data"}, blk_data, EXP_DATA);
        check({tag, "_blk_key"}, blk_key, EXP_KEY);
    endtask

    // From START, count cycles until done_pulse, bounded
    task automatic wait_done(input string tag, input int exp_ticks);
        int n;
        n = 0;
        while (done_pulse !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_done_latency"}, n, exp_ticks);
        check({tag, "_busy_after_done"}, busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_abort   = 1'b0;
        core_done = 1'b1;
        tick();
        tick();
        check("rst_blk_data", blk_data, 128'h0);
        check("rst_blk_key", blk_key, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_core_rst", core_rst, 1'b0);
        check("rst_done_err", {done_pulse, err}, 2'b00);
        rst = 1'b0;
        check("rel_s_ready", s_ready, 1'b1);

        // Nominal load with stale core_done held high throughout
        load_vector("nom");
        tick();
        check("nom_core_rst_one_cycle", core_rst, 1'b0);
        check("nom_wait1", {busy, done_pulse}, 2'b10);
        tick();
        check("nom_wait2", {busy, done_pulse}, 2'b10);
        tick();
        check("nom_wait3", {busy, done_pulse}, 2'b10);
        tick();
        check("nom_done_pulse", {busy, done_pulse}, 2'b01);
        check("nom_s_ready", s_ready, 1'b1);
        tick();
        check("nom_done_one_cycle", done_pulse, 1'b0);
        check("nom_rst_pulses", rst_pulses, 1);

        // Timeout: core_done stuck low for 32 WAIT cycles
        core_done = 1'b0;
        load_vector("tmo");
        repeat (32) tick();
        check("tmo_still_waiting", {busy, err}, 2'b10);
        tick();
        check("tmo_err_set", {busy, err, done_pulse}, 3'b010);
        check("tmo_s_ready", s_ready, 1'b1);
        tick();
        check("tmo_err_sticky", err, 1'b1);
        send(8'h5a);
        check("tmo_err_cleared", err, 1'b0);
        s_abort = 1'b1;
        #1;
        check("abort_s_ready_low", s_ready, 1'b0);
        tick();
        s_abort = 1'b0;

        // Done arriving on the final timeout cycle wins over the timeout
        load_vector("prio");
        repeat (32) tick();
        check("prio_before", {busy, err}, 2'b10);
        core_done = 1'b1;
        tick();
        check("prio_done_wins", {busy, done_pulse, err}, 3'b010);
        tick();

        // Abort after 20 transfers, then a full reload
        base = rst_pulses;
        for (int i = 0; i < 20; i++) send(8'(8'ha5 ^ 8'(i)));
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        check("abort_back_to_data", busy, 1'b0);
        check("abort_no_core_rst", rst_pulses, base);
        load_vector("abort");
        wait_done("abort", 4);
        check("abort_rst_pulses", rst_pulses, base + 1);

        // Back-pressure: random gaps with junk data and a 10-cycle pause mid-key
        for (int i = 0; i < 32; i++) begin
            int gap;
            if (i == 24) begin
                repeat (10) begin
                    s_data = 8'($urandom);
                    tick();
                end
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                s_data = 8'($urandom);
                tick();
            end
            if (i < 16) send(8'(i * 17));
            else        send(8'(i - 16));
        end
        check("bp_core_rst", core_rst, 1'b1);
        check("bp_blk_data", blk_data, EXP_DATA);
        check("bp_blk_key", blk_key, EXP_KEY);
        wait_done("bp", 4);

        // Reset during WAIT
        load_vector("rw");
        tick();
        check("rw_in_wait", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("rw_outputs", {blk_data, blk_key}, 256'h0);
        check("rw_flags", {busy, core_rst, done_pulse, err}, 4'b0000);
        rst = 1'b0;
        check("rw_s_ready", s_ready, 1'b1);

        // Reset at byte 7, then a full load
        base = rst_pulses;
        for (int i = 0; i < 7; i++) send(8'(i * 17));
        rst = 1'b1;
        tick();
        check("rb_blk_data", blk_data, 128'h0);
        check("rb_flags", {busy, core_rst}, 2'b00);
        rst = 1'b0;
        load_vector("rb");
        wait_done("rb", 4);
        check("rb_rst_pulses", rst_pulses, base + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
